// File: rtl/shift_arbiter_pkg.sv
// shift_arbiter_pkg: shared widths, output-state encoding and requester id type for shift_arbiter.
// ARITH_EN follows the SHIFT_ARBITER_ARITH_EN macro.
package shift_arbiter_pkg;
    localparam int WIDTH = 32;
    localparam int SHW = 5;
`ifdef SHIFT_ARBITER_ARITH_EN
    localparam bit ARITH_EN = 1'b1;
`else
    localparam bit ARITH_EN = 1'b0;
`endif
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;
    typedef logic req_id_t;
endpackage

// File: rtl/shift_core.sv
// shift_core: combinational 5-stage logarithmic right shifter with a fill-bit input.
module shift_core
    import shift_arbiter_pkg::*;
(
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_sha,
    input  logic             i_fill,
    output logic [WIDTH-1:0] o_data
);
    logic [WIDTH-1:0] w_stage [SHW+1];
    assign w_stage[0] = i_data;
    for (genvar g = 0; g < SHW; g++) begin : g_stage
        assign w_stage[g+1] = i_sha[g] ? {{(1 << g){i_fill}}, w_stage[g][WIDTH-1:(1 << g)]} : w_stage[g];
    end
    assign o_data = w_stage[SHW];
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbitration of two requesters onto one shared right shifter
// with a one-entry output register. Arithmetic shifts only when SHIFT_ARBITER_ARITH_EN is defined.
module shift_arbiter #(
    parameter int WIDTH = shift_arbiter_pkg::WIDTH,
    parameter int SHW   = shift_arbiter_pkg::SHW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_sha,
    input  logic             req0_arith,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_sha,
    input  logic             req1_arith,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);
    import shift_arbiter_pkg::*;
    out_state_t       r_state, w_state_nxt;
    logic             r_ptr;
    logic [WIDTH-1:0] r_data;
    req_id_t          r_id;
    logic             w_accept, w_gnt0, w_gnt1, w_fill;
    logic [WIDTH-1:0] w_data, w_shift;
    logic [SHW-1:0]   w_sha;
    // rst_n gating keeps both readies low during reset even though the state is EMPTY
    assign w_accept = rst_n && (r_state == EMPTY || rsp_ready);
    assign w_gnt0   = w_accept && req0_valid && (!req1_valid || !r_ptr);
    assign w_gnt1   = w_accept && req1_valid && (!req0_valid || r_ptr);
    assign w_data   = w_gnt1 ? req1_data : req0_data;
    assign w_sha    = w_gnt1 ? req1_sha : req0_sha;
    assign w_fill   = ARITH_EN && (w_gnt1 ? req1_arith : req0_arith) && w_data[WIDTH-1];
    shift_core u_core (
        .i_data (w_data),
        .i_sha  (w_sha),
        .i_fill (w_fill),
        .o_data (w_shift)
    );
    always_comb begin
        w_state_nxt = (w_gnt0 || w_gnt1) ? FULL : (rsp_ready ? EMPTY : r_state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_ptr   <= 1'b0;
            r_data  <= '0;
            r_id    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0 || w_gnt1) begin
                r_data <= w_shift;
                r_id   <= req_id_t'(w_gnt1);
                r_ptr  <= ~w_gnt1;
            end
        end
    end
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp_valid  = (r_state == FULL);
    assign rsp_data   = r_data;
    assign rsp_id     = r_id;
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: scoreboard bench for shift_arbiter with directed cases and randomized traffic.
module tb_shift_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_arith;
    logic        req1_valid, req1_ready, req1_arith;
    logic [31:0] req0_data, req1_data, rsp_data;
    logic [4:0]  req0_sha, req1_sha;
    logic        rsp_valid, rsp_ready, rsp_id;
    int checks = 0;
    int errors = 0;
    typedef struct {logic [31:0] d; logic id;} rsp_t;
    rsp_t q[$];
    logic m_full, m_ptr;

    shift_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_sha(req0_sha), .req0_arith(req0_arith),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_sha(req1_sha), .req1_arith(req1_arith),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] s, input logic a);
        logic signed [31:0] sd;
        sd = d;
`ifdef SHIFT_ARBITER_ARITH_EN
        if (a) return sd >>> s;
`endif
        return d >> s;
    endfunction

    // reference model: predicts grants and pushes expected results
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 1'b0;
            q.delete();
        end else begin
            logic acc, g0, g1;
            acc = !m_full || rsp_ready;
            g0  = acc && req0_valid && (!req1_valid || !m_ptr);
            g1  = acc && req1_valid && (!req0_valid || m_ptr);
            chk("req0_ready", {31'b0, req0_ready}, {31'b0, g0});
            chk("req1_ready", {31'b0, req1_ready}, {31'b0, g1});
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_full});
            if (g0) begin q.push_back('{ref_shift(req0_data, req0_sha, req0_arith), 1'b0}); m_ptr = 1'b1; end
            if (g1) begin q.push_back('{ref_shift(req1_data, req1_sha, req1_arith), 1'b1}); m_ptr = 1'b0; end
            m_full = g0 || g1 || (m_full && !rsp_ready);
        end
    end

    // monitor: held result must match the oldest expected entry every cycle it is valid
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
            end else begin
                chk("rsp_data", rsp_data, q[0].d);
                chk("rsp_id", {31'b0, rsp_id}, {31'b0, q[0].id});
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic a0, a1;
        rst_n = 1'b0;
        {req0_valid, req1_valid, req0_arith, req1_arith, rsp_ready} = '0;
        {req0_data, req1_data} = '0;
        {req0_sha, req1_sha} = '0;
        #1;
        chk("reset_rdy0", {31'b0, req0_ready}, 32'h0);
        chk("reset_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset_data", rsp_data, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        // single requester, max shift
        req0_valid = 1; req0_data = 32'h80000000; req0_sha = 31; req0_arith = 0; rsp_ready = 1;
        step();
        req0_valid = 0;
        chk("r033_valid", {31'b0, rsp_valid}, 32'h1);
        chk("r033_data", rsp_data, 32'h00000001);
        chk("r033_id", {31'b0, rsp_id}, 32'h0);
        step();
        // contention after reset
        do_reset();
        req0_valid = 1; req0_data = 32'h0000FF00; req0_sha = 8;
        req1_valid = 1; req1_data = 32'h12345678; req1_sha = 4; req1_arith = 0;
        step();
        req0_valid = 0;
        chk("r034_a", rsp_data, 32'h000000FF);
        chk("r034_a_id", {31'b0, rsp_id}, 32'h0);
        step();
        req1_valid = 0;
        chk("r034_b", rsp_data, 32'h01234567);
        chk("r034_b_id", {31'b0, rsp_id}, 32'h1);
        step();
        // back-pressure for 3 cycles
        rsp_ready = 0;
        req0_valid = 1; req0_data = 32'hA5A5A5A5; req0_sha = 3;
        req1_valid = 1; req1_data = 32'h0F0F0F0F; req1_sha = 1;
        step();
        req0_valid = 0;
        repeat (3) begin
            step();
            chk("r035_stall_data", rsp_data, 32'h14B4B4B4);
            chk("r035_stall_rdy", {30'b0, req0_ready, req1_ready}, 32'h0);
        end
        rsp_ready = 1;
        #1;
        chk("r035_regrant", {31'b0, req1_ready}, 32'h1);
        step();
        req1_valid = 0;
        chk("r035_new", rsp_data, 32'h07878787);
        step();
        // arithmetic vs logical fill
        req0_valid = 1; req0_data = 32'h80000000; req0_sha = 4; req0_arith = 1;
        step();
        req0_valid = 0;
`ifdef SHIFT_ARBITER_ARITH_EN
        chk("r036_arith", rsp_data, 32'hF8000000);
`else
        chk("r036_arith", rsp_data, 32'h08000000);
`endif
        step();
        req0_valid = 1; req0_data = 32'hDEADBEEF; req0_sha = 0; req0_arith = 1;
        step();
        req0_valid = 0;
        chk("r038_sha0", rsp_data, 32'hDEADBEEF);
        step();
        // async reset while FULL with pointer at requester 1
        rsp_ready = 0;
        req0_valid = 1; req0_data = 32'h11110000; req0_sha = 16; req0_arith = 0;
        step();
        req0_valid = 0;
        #1;
        rst_n = 0;
        #1;
        chk("r037_drop", {31'b0, rsp_valid}, 32'h0);
        chk("r037_rdy", {30'b0, req0_ready, req1_ready}, 32'h0);
        rst_n = 1;
        rsp_ready = 1;
        req0_valid = 1; req0_data = 32'h00000100; req0_sha = 8;
        req1_valid = 1; req1_data = 32'h00000200; req1_sha = 8;
        step();
        req0_valid = 0;
        chk("r037_ptr", {31'b0, rsp_id}, 32'h0);
        step();
        req1_valid = 0;
        step();
        // randomized traffic with hold-until-accepted requesters
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (!req0_valid || a0) begin
                req0_valid = 1'($urandom % 2); req0_data = $urandom;
                req0_sha = 5'($urandom); req0_arith = 1'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = 1'($urandom % 2); req1_data = $urandom;
                req1_sha = 5'($urandom); req1_arith = 1'($urandom);
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (a0) req0_valid = 0;
        if (a1) req1_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < 20 && (q.size() != 0 || req0_valid || req1_valid); i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if (a0) req0_valid = 0;
            if (a1) req1_valid = 0;
        end
        step();
        chk("drain", q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
